// File: rtl/gray_cnt_pkg.sv
// gray_cnt_pkg: shared mode enum and width-agnostic Gray/binary conversion helpers.
package gray_cnt_pkg;
  localparam int GW = 64;
  typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;
  // Callers zero-extend to GW bits and truncate the result back to their own width.
  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    for (int k = 0; k < GW; k++) b[k] = ^(g >> k);
    return b;
  endfunction
endpackage

// File: rtl/gray_cnt_chan.sv
// gray_cnt_chan: one up/down counter channel with Gray image and flags, all registered from one next value.
import gray_cnt_pkg::*;
module gray_cnt_chan #(
  parameter int        W    = 8,
  parameter cnt_mode_e MODE = CNT_WRAP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic [W-1:0] gray,
  output logic         wrap,
  output logic         at_max,
  output logic         at_min
);
  logic [W-1:0] cnt_q, cnt_d, gray_q, gray_d;
  logic         wrap_q, wrap_d, at_max_q, at_max_d, at_min_q, at_min_d;
  logic         up, dn, top, bot, sat;
  always_comb begin
    sat      = (MODE == CNT_SAT);
    up       = inc & ~dec;
    dn       = dec & ~inc;
    top      = (cnt_q == '1);
    bot      = (cnt_q == '0);
    cnt_d    = clr ? '0 :
               (up && !(sat && top)) ? cnt_q + 1'b1 :
               (dn && !(sat && bot)) ? cnt_q - 1'b1 : cnt_q;
    wrap_d   = ~clr & ((up & top) | (dn & bot));
    gray_d   = W'(bin2gray(GW'(cnt_d)));
    at_max_d = (cnt_d == '1);
    at_min_d = (cnt_d == '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      gray_q   <= '0;
      wrap_q   <= 1'b0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      gray_q   <= gray_d;
      wrap_q   <= wrap_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
    end
  end
  assign cnt    = cnt_q;
  assign gray   = gray_q;
  assign wrap   = wrap_q;
  assign at_max = at_max_q;
  assign at_min = at_min_q;
endmodule

// File: rtl/gray_cnt_bank.sv
// gray_cnt_bank: N-channel Gray-coded event counter bank; GRAY_CNT_RX_EN adds a remote Gray-count receive synchroniser.
import gray_cnt_pkg::*;
module gray_cnt_bank #(
  parameter int W   = 8,
  parameter int N   = 4,
  parameter int SAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   inc,
  input  logic [N-1:0]   dec,
  input  logic [N-1:0]   clr,
  output logic [N*W-1:0] cnt,
  output logic [N*W-1:0] gray,
  output logic [N-1:0]   wrap,
  output logic [N-1:0]   at_max,
`ifdef GRAY_CNT_RX_EN
  input  logic [N*W-1:0] rx_gray,
  output logic [N*W-1:0] rx_cnt,
`endif
  output logic [N-1:0]   at_min
);
  localparam cnt_mode_e MODE = (SAT != 0) ? CNT_SAT : CNT_WRAP;
  for (genvar i = 0; i < N; i++) begin : g_chan
    gray_cnt_chan #(.W(W), .MODE(MODE)) u_chan (
      .clk(clk), .rst(rst), .inc(inc[i]), .dec(dec[i]), .clr(clr[i]),
      .cnt(cnt[i*W +: W]), .gray(gray[i*W +: W]), .wrap(wrap[i]),
      .at_max(at_max[i]), .at_min(at_min[i])
    );
  end
`ifdef GRAY_CNT_RX_EN
  logic [N*W-1:0] s1_q, s2_q, rx_cnt_q, rx_cnt_d;
  always_comb begin
    rx_cnt_d = '0;
    for (int c = 0; c < N; c++) rx_cnt_d[c*W +: W] = W'(gray2bin(GW'(s2_q[c*W +: W])));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      rx_cnt_q <= '0;
    end else begin
      s1_q     <= rx_gray;
      s2_q     <= s1_q;
      rx_cnt_q <= rx_cnt_d;
    end
  end
  assign rx_cnt = rx_cnt_q;
`endif
endmodule

// File: tb/tb_gray_cnt_bank.sv
// tb_gray_cnt_bank: directed checks of a wrap-mode and a saturate-mode bank (W=4, N=2).
module tb_gray_cnt_bank;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] inc = '0, dec = '0, clr = '0;
  logic [1:0] sinc = '0, sdec = '0, sclr = '0;
  logic [7:0] cnt, gray, scnt, sgray;
  logic [1:0] wrap, at_max, at_min, swrap, sat_max, sat_min;
  logic [3:0] prev_g;
  int n_cmp = 0, n_err = 0;
`ifdef GRAY_CNT_RX_EN
  logic [7:0] rx_gray = '0, rx_cnt, srx_cnt;
`endif
  always #5 clk = ~clk;

  gray_cnt_bank #(.W(4), .N(2), .SAT(0)) dut_w (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr),
    .cnt(cnt), .gray(gray), .wrap(wrap), .at_max(at_max),
`ifdef GRAY_CNT_RX_EN
    .rx_gray(rx_gray), .rx_cnt(rx_cnt),
`endif
    .at_min(at_min)
  );
  gray_cnt_bank #(.W(4), .N(2), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .inc(sinc), .dec(sdec), .clr(sclr),
    .cnt(scnt), .gray(sgray), .wrap(swrap), .at_max(sat_max),
`ifdef GRAY_CNT_RX_EN
    .rx_gray(8'h00), .rx_cnt(srx_cnt),
`endif
    .at_min(sat_min)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1'b1;
    inc = 2'b11;
    sinc = 2'b11;
    #1;
    chk("rst_async_cnt", 32'(cnt), 32'h00);
    chk("rst_async_at_min", 32'(at_min), 32'h3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_cnt", 32'(cnt), 32'h00);
      chk("rst_gray", 32'(gray), 32'h00);
      chk("rst_at_min", 32'(at_min), 32'h3);
      chk("rst_at_max", 32'(at_max), 32'h0);
      chk("rst_wrap", 32'(wrap), 32'h0);
      chk("rst_scnt", 32'(scnt), 32'h00);
    end
    inc = 2'b01;
    sinc = 2'b00;
    rst = 1'b0;
    step();
    chk("first_inc_cnt", 32'(cnt), 32'h01);
    chk("first_inc_gray", 32'(gray), 32'h01);
    chk("first_inc_at_min", 32'(at_min), 32'h2);
    prev_g = gray[3:0];
    for (int k = 2; k <= 15; k++) begin
      step();
      chk("walk_cnt", 32'(cnt[3:0]), 32'(k));
      chk("walk_onebit", 32'($countones(gray[3:0] ^ prev_g)), 32'd1);
      prev_g = gray[3:0];
    end
    chk("max_gray", 32'(gray[3:0]), 32'h8);
    chk("max_flag", 32'(at_max), 32'h1);
    chk("max_nowrap", 32'(wrap), 32'h0);
    step();
    chk("wrap_cnt", 32'(cnt), 32'h00);
    chk("wrap_gray", 32'(gray), 32'h00);
    chk("wrap_onebit", 32'($countones(gray[3:0] ^ prev_g)), 32'd1);
    chk("wrap_pulse", 32'(wrap), 32'h1);
    chk("wrap_at_min", 32'(at_min), 32'h3);
    inc = 2'b00;
    step();
    chk("wrap_pulse_end", 32'(wrap), 32'h0);
    dec = 2'b10;
    step();
    chk("underflow_cnt", 32'(cnt), 32'hF0);
    chk("underflow_gray", 32'(gray), 32'h80);
    chk("underflow_pulse", 32'(wrap), 32'h2);
    chk("underflow_at_max", 32'(at_max), 32'h2);
    dec = 2'b00;
    sdec = 2'b10;
    step();
    chk("sat_min_cnt", 32'(scnt), 32'h00);
    chk("sat_min_pulse", 32'(swrap), 32'h2);
    chk("sat_min_gray", 32'(sgray), 32'h00);
    chk("wrap_idle_pulse", 32'(wrap), 32'h0);
    sdec = 2'b00;
    sinc = 2'b10;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("sat_up_cnt", 32'(scnt[7:4]), 32'(k));
      chk("sat_up_nopulse", 32'(swrap), 32'h0);
    end
    step();
    chk("sat_max_cnt", 32'(scnt), 32'hF0);
    chk("sat_max_gray", 32'(sgray), 32'h80);
    chk("sat_max_pulse", 32'(swrap), 32'h2);
    chk("sat_max_flag", 32'(sat_max), 32'h2);
    sinc = 2'b00;
    step();
    chk("sat_pulse_end", 32'(swrap), 32'h0);
    inc = 2'b01;
    for (int k = 0; k < 9; k++) step();
    chk("pre_prio_cnt", 32'(cnt), 32'hF9);
    chk("pre_prio_gray", 32'(gray), 32'h8D);
    clr = 2'b01;
    dec = 2'b01;
    step();
    chk("prio_cnt", 32'(cnt), 32'hF0);
    chk("prio_gray", 32'(gray), 32'h80);
    chk("prio_nopulse", 32'(wrap), 32'h0);
    clr = 2'b00;
    step();
    chk("both_cnt", 32'(cnt), 32'hF0);
    chk("both_nopulse", 32'(wrap), 32'h0);
    inc = 2'b00;
    dec = 2'b00;
    clr = 2'b11;
    step();
    chk("clr_cnt", 32'(cnt), 32'h00);
    chk("clr_nopulse", 32'(wrap), 32'h0);
    clr = 2'b00;
    inc = 2'b10;
    for (int k = 0; k < 5; k++) step();
    chk("ch1_five", 32'(cnt), 32'h50);
    inc = 2'b01;
    dec = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("indep_cnt", 32'(cnt), 32'((5 - k) * 16 + k));
    end
    chk("indep_gray", 32'(gray), 32'h16);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(cnt), 32'h00);
    chk("async_rst_gray", 32'(gray), 32'h00);
    chk("async_rst_at_min", 32'(at_min), 32'h3);
    chk("async_rst_scnt", 32'(scnt), 32'h00);
    step();
    chk("rst_hold_cnt", 32'(cnt), 32'h00);
    rst = 1'b0;
    dec = 2'b00;
    step();
    chk("post_rst_cnt", 32'(cnt), 32'h01);
    inc = 2'b00;
`ifdef GRAY_CNT_RX_EN
    rx_gray = 8'h0D;
    step();
    chk("rx_edge1", 32'(rx_cnt), 32'h00);
    step();
    chk("rx_edge2", 32'(rx_cnt), 32'h00);
    step();
    chk("rx_edge3", 32'(rx_cnt), 32'h09);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
